// File: rtl/alu_pipe.sv
// Two-stage ALU with an iterative shift-add multiplier and valid/ready handshakes on both sides.
// Latency: ops 000-110 give a result one cycle after acceptance; MUL gives it WIDTH cycles after acceptance.
// Backpressure: in_ready drops while a MUL runs or while a held result is not being consumed; nothing is overwritten.
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_SLTU = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t state, state_nxt;

    // Capture stage for the single-cycle ops
    logic             s1_vld;
    logic [2:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    // Multiplier datapath: multiplicand shifts left, multiplier shifts right
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    logic             out_free;
    logic             accept;
    logic             mul_last;
    logic             mul_step;
    logic             load_alu;
    logic             load_mul;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [WIDTH-1:0] nxt_res;
    logic             nxt_c;
    logic             nxt_v;

    assign out_free = !out_valid || out_ready;
    assign in_ready = (state == IDLE) && out_free;
    assign accept   = in_valid && in_ready;
    assign mul_last = (cnt == CW'(WIDTH - 1));
    // The last multiply step writes the output register, so it waits for it to be free
    assign mul_step = (state == MUL) && (!mul_last || out_free);
    // A captured op stalls in place while the output is held, since in_ready is low then too
    assign load_alu = s1_vld && out_free;
    assign load_mul = (state == MUL) && mul_last && out_free;

    assign sum      = {1'b0, s1_a} + {1'b0, s1_b};
    assign diff     = {1'b0, s1_a} + {1'b0, ~s1_b} + (WIDTH + 1)'(1);
    assign prod_nxt = prod + (mplier[0] ? mcand : '0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: enter MUL on a multiply acceptance, leave when the final step loads the output
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && op == OP_MUL) state_nxt = MUL;
            MUL:     if (load_mul) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture operands of single-cycle ops; release when they move to the output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_op  <= 3'b000;
            s1_a   <= '0;
            s1_b   <= '0;
        end else if (accept && op != OP_MUL) begin
            s1_vld <= 1'b1;
            s1_op  <= op;
            s1_a   <= a;
            s1_b   <= b;
        end else if (load_alu) begin
            s1_vld <= 1'b0;
        end
    end

    // Shift-add multiplier, one multiplier bit per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            cnt    <= '0;
        end else if (accept && op == OP_MUL) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            prod   <= '0;
            cnt    <= '0;
        end else if (mul_step) begin
            prod   <= prod_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
        end
    end

    // Single-cycle op result and flags from the capture stage
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (s1_op)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = ~diff[WIDTH];
                alu_v   = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != s1_a[WIDTH-1]);
            end
            OP_AND:  alu_res = s1_a & s1_b;
            OP_OR:   alu_res = s1_a | s1_b;
            OP_XOR:  alu_res = s1_a ^ s1_b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (s1_a < s1_b)};
            default: alu_res = '0;
        endcase
    end

    // Select which source feeds the output register
    always_comb begin
        nxt_res = prod_nxt[WIDTH-1:0];
        nxt_c   = 1'b0;
        nxt_v   = |prod_nxt[2*WIDTH-1:WIDTH];
        if (load_alu) begin
            nxt_res = alu_res;
            nxt_c   = alu_c;
            nxt_v   = alu_v;
        end
    end

    // Output register: load a new result, otherwise hold until consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else if (load_alu || load_mul) begin
            out_valid <= 1'b1;
            result    <= nxt_res;
            carry     <= nxt_c;
            overflow  <= nxt_v;
            zero      <= ~|nxt_res;
            negative  <= nxt_res[WIDTH-1];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
